// File: rtl/channel_mean_stats.sv
// Per-channel frame mean engine: accumulates sum/count per colour channel between
// sof and eof, then divides each channel with one shared restoring divider.
//
// state  | meaning
// IDLE   | waiting for a sof pixel; everything else ignored
// ACCUM  | accumulating pixels of the current frame
// DIVIDE | one settle cycle, then per channel: load + SUM_W quotient bits
module channel_mean_stats #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 20,
  localparam int SUM_W = DATA_W + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     sof_i,
  input  logic                     eof_i,
  output logic [NUM_CH*DATA_W-1:0] mean_o,
  output logic                     mean_valid_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam int IT_W = (SUM_W > 2) ? $clog2(SUM_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] MEAN_MAX = '1;

  logic [1:0]        state;
  logic              v_q, sof_q, eof_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] d_q;

  logic [SUM_W-1:0]  sum_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_r [NUM_CH];
  logic [DATA_W-1:0] mean_stage [NUM_CH];

  logic              settle, div_load;
  logic [CH_W-1:0]   div_ch;
  logic [IT_W-1:0]   it_cnt;
  logic [CNT_W-1:0]  rem, dvs;
  logic [SUM_W-1:0]  dq;

  logic [SUM_W-1:0]  sel_sum;
  logic [CNT_W-1:0]  sel_cnt;
  logic [CNT_W:0]    rem_sh;
  logic              ge;
  logic [CNT_W-1:0]  diff, rem_n;
  logic [SUM_W-1:0]  dq_n;
  logic [DATA_W-1:0] quo;

  assign busy_o = (state == S_DIVIDE) && !settle;

  always_comb begin
    sel_sum = '0;
    sel_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (div_ch == CH_W'(c)) begin
        sel_sum = sum_r[c];
        sel_cnt = cnt_r[c];
      end
    end
  end

  // One restoring step; remainder stays below the divisor so CNT_W bits suffice.
  always_comb begin
    rem_sh = {rem, dq[SUM_W-1]};
    ge     = rem_sh >= {1'b0, dvs};
    diff   = rem_sh[CNT_W-1:0] - dvs;
    rem_n  = ge ? diff : rem_sh[CNT_W-1:0];
    dq_n   = {dq[SUM_W-2:0], ge};
    if (dvs == '0)
      quo = '0;
    else if (dq_n > {{CNT_W{1'b0}}, MEAN_MAX})
      quo = MEAN_MAX;
    else
      quo = dq_n[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      v_q          <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      ch_q         <= '0;
      d_q          <= '0;
      settle       <= 1'b0;
      div_load     <= 1'b0;
      div_ch       <= '0;
      it_cnt       <= '0;
      rem          <= '0;
      dvs          <= '0;
      dq           <= '0;
      mean_o       <= '0;
      mean_valid_o <= 1'b0;
      err_o        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_r[c]      <= '0;
        cnt_r[c]      <= '0;
        mean_stage[c] <= '0;
      end
    end else begin
      v_q          <= valid_i;
      sof_q        <= sof_i;
      eof_q        <= eof_i;
      ch_q         <= ch_i;
      d_q          <= data_i;
      mean_valid_o <= 1'b0;
      case (state)
        S_IDLE, S_ACCUM: begin
          settle <= 1'b1;
          if (v_q && sof_q) begin
            err_o <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              sum_r[c] <= (ch_q == CH_W'(c)) ? SUM_W'(d_q) : '0;
              cnt_r[c] <= (ch_q == CH_W'(c)) ? CNT_W'(1) : '0;
            end
            state <= eof_q ? S_DIVIDE : S_ACCUM;
          end else if (v_q && state == S_ACCUM) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (ch_q == CH_W'(c)) begin
                if (cnt_r[c] == CNT_MAX) begin
                  err_o <= 1'b1;
                end else begin
                  sum_r[c] <= sum_r[c] + SUM_W'(d_q);
                  cnt_r[c] <= cnt_r[c] + CNT_W'(1);
                end
              end
            end
            if (eof_q)
              state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (v_q)
            err_o <= 1'b1;
          if (settle) begin
            settle   <= 1'b0;
            div_load <= 1'b1;
            div_ch   <= '0;
          end else if (div_load) begin
            rem      <= '0;
            dq       <= sel_sum;
            dvs      <= sel_cnt;
            it_cnt   <= IT_W'(SUM_W - 1);
            div_load <= 1'b0;
          end else begin
            rem <= rem_n;
            dq  <= dq_n;
            if (it_cnt == '0) begin
              if (div_ch == CH_W'(NUM_CH - 1)) begin
                for (int c = 0; c < NUM_CH; c++)
                  mean_o[c*DATA_W +: DATA_W] <= (c == NUM_CH - 1) ? quo : mean_stage[c];
                mean_valid_o <= 1'b1;
                state        <= S_IDLE;
              end else begin
                for (int c = 0; c < NUM_CH; c++)
                  if (div_ch == CH_W'(c))
                    mean_stage[c] <= quo;
                div_ch   <= div_ch + CH_W'(1);
                div_load <= 1'b1;
              end
            end else begin
              it_cnt <= it_cnt - IT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_mean_stats.sv
// Scoreboard bench for channel_mean_stats: a default instance and a CNT_W=2 instance
// share stimulus; a frame-level model predicts means, error flag and timing.
module tb_channel_mean_stats;

  localparam int NCH = 3;
  localparam int CW_A = 20;
  localparam int CW_B = 2;

  typedef struct {
    logic [23:0] means;
    bit          err;
    int          eof_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [1:0]  ch = '0;
  logic [7:0]  data = '0;
  logic [23:0] mean [2];
  logic [1:0]  mv, busy, err;
  logic [1:0]  busy_d = '0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lat [2];
  int   maxc [2];
  exp_t q [2][$];
  int   fr_ch[$];
  int   fr_d[$];
  bit   in_frame = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  channel_mean_stats #(.DATA_W(8), .NUM_CH(NCH), .CH_W(2), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ch_i(ch), .data_i(data),
    .sof_i(sof), .eof_i(eof), .mean_o(mean[0]), .mean_valid_o(mv[0]),
    .busy_o(busy[0]), .err_o(err[0]));

  channel_mean_stats #(.DATA_W(8), .NUM_CH(NCH), .CH_W(2), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ch_i(ch), .data_i(data),
    .sof_i(sof), .eof_i(eof), .mean_o(mean[1]), .mean_valid_o(mv[1]),
    .busy_o(busy[1]), .err_o(err[1]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level reference: plain per-channel sums with count ceiling, integer mean.
  function automatic exp_t model(input int maxcnt, input int ec);
    exp_t   x;
    longint s [NCH];
    longint n [NCH];
    longint m;
    x.err = 1'b0;
    x.eof_cyc = ec;
    x.means = '0;
    for (int c = 0; c < NCH; c++) begin
      s[c] = 0;
      n[c] = 0;
    end
    foreach (fr_ch[i]) begin
      if (fr_ch[i] < NCH) begin
        if (n[fr_ch[i]] == maxcnt) x.err = 1'b1;
        else begin
          s[fr_ch[i]] += fr_d[i];
          n[fr_ch[i]] += 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      m = (n[c] != 0) ? s[c] / n[c] : 0;
      if (m > 255) m = 255;
      x.means[c*8 +: 8] = m[7:0];
    end
    return x;
  endfunction

  task automatic idle(input int n);
    valid = 1'b0;
    sof = 1'b0;
    eof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int c, input int d, input bit s, input bit e);
    valid = 1'b1;
    ch = c[1:0];
    data = d[7:0];
    sof = s;
    eof = e;
    if (s) begin
      fr_ch.delete();
      fr_d.delete();
      in_frame = 1'b1;
    end
    if (in_frame) begin
      fr_ch.push_back(c);
      fr_d.push_back(d);
      if (e) begin
        for (int i = 0; i < 2; i++) q[i].push_back(model(maxc[i], cyc + 1));
        in_frame = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Pixel offered while the divider runs: must be dropped and flag the frame.
  task automatic inject(input int c, input int d, input bit s, input bit e);
    valid = 1'b1;
    ch = c[1:0];
    data = d[7:0];
    sof = s;
    eof = e;
    for (int i = 0; i < 2; i++)
      if (q[i].size() > 0) q[i][q[i].size()-1].err = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q[0].size() > 0 || q[1].size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d/%0d results outstanding, required 0", q[0].size(), q[1].size());
      q[0].delete();
      q[1].delete();
    end
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_mean%0d", i), mean[i], 0);
      check($sformatf("rst_valid%0d", i), mv[i], 0);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_err%0d", i), err[i], 0);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (busy[i] && !busy_d[i]) begin
          if (q[i].size() > 0) check($sformatf("busy_rise%0d", i), cyc, q[i][0].eof_cyc + 2);
          else check($sformatf("spurious_busy%0d", i), busy[i], 0);
        end
        if (mv[i]) begin
          if (q[i].size() == 0) check($sformatf("spurious_valid%0d", i), mv[i], 0);
          else begin
            x = q[i].pop_front();
            for (int c = 0; c < NCH; c++)
              check($sformatf("mean%0d_ch%0d", i, c), mean[i][c*8 +: 8], x.means[c*8 +: 8]);
            check($sformatf("err%0d", i), err[i], x.err);
            check($sformatf("latency%0d", i), cyc, x.eof_cyc + lat[i]);
            check($sformatf("busy_fall%0d", i), busy[i], 0);
          end
        end
      end
      busy_d[i] = busy[i];
    end
  end

  initial begin
    int len, rc;
    bit last;
    lat[0] = NCH * (8 + CW_A + 1) + 2;
    lat[1] = NCH * (8 + CW_B + 1) + 2;
    maxc[0] = (1 << CW_A) - 1;
    maxc[1] = (1 << CW_B) - 1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    idle(2);

    // 16 pixels ch0 value 10
    for (int p = 0; p < 16; p++) drive(0, 10, p == 0, p == 15);
    wait_done();

    // ch1 {1,2,2} mixed with five ch2 255
    drive(1, 1, 1, 0);
    drive(2, 255, 0, 0);
    drive(1, 2, 0, 0);
    drive(2, 255, 0, 0);
    drive(2, 255, 0, 0);
    drive(1, 2, 0, 0);
    drive(2, 255, 0, 0);
    drive(2, 255, 0, 1);
    wait_done();

    // single-pixel frame, then a frame with invalid channel ids interleaved
    drive(0, 200, 1, 1);
    wait_done();
    drive(0, 50, 1, 0);
    drive(3, 99, 0, 0);
    drive(0, 52, 0, 0);
    drive(3, 7, 0, 0);
    drive(1, 9, 0, 1);
    wait_done();

    // pixels offered while busy are dropped; err stays until next sof
    drive(2, 40, 1, 0);
    drive(2, 60, 0, 1);
    idle(3);
    inject(0, 123, 1, 0);
    inject(1, 77, 0, 1);
    inject(2, 5, 1, 1);
    wait_done();
    idle(1);
    for (int i = 0; i < 2; i++) check($sformatf("err_sticky%0d", i), err[i], 1);
    drive(0, 30, 1, 0);
    drive(0, 31, 0, 0);
    for (int i = 0; i < 2; i++) check($sformatf("err_cleared%0d", i), err[i], 0);
    drive(0, 32, 0, 1);
    wait_done();

    // four ch0 pixels of 8: the CNT_W=2 instance saturates at 3
    for (int p = 0; p < 4; p++) drive(0, 8, p == 0, p == 3);
    wait_done();

    // randomized frames with bubbles, stray idle pixels and restarts
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 2) == 0) drive($urandom_range(0, 3), $urandom_range(0, 255), 0, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        drive($urandom_range(0, 2), $urandom_range(0, 255), 1, 0);
        for (int p = 0; p < 3; p++) drive($urandom_range(0, 3), $urandom_range(0, 255), 0, 0);
      end
      for (int p = 0; p < len; p++) begin
        last = (p == len - 1);
        if ($urandom_range(0, 4) == 0) idle(1);
        rc = last ? $urandom_range(0, 2) : $urandom_range(0, 3);
        drive(rc, (f % 3 == 0) ? 255 : $urandom_range(0, 255), p == 0, last);
      end
      wait_done();
    end

    // reset in the middle of DIVIDE
    for (int p = 0; p < 5; p++) drive(1, 100 + p, p == 0, p == 4);
    idle(20);
    rst_n = 1'b0;
    #1;
    q[0].delete();
    q[1].delete();
    in_frame = 1'b0;
    check_reset_vals();
    idle(2);
    rst_n = 1'b1;
    idle(120);
    drive(0, 17, 1, 0);
    drive(1, 90, 0, 0);
    drive(2, 3, 0, 0);
    drive(0, 18, 0, 1);
    wait_done();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
